// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        operation request, accepted only when idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   cand, er     multiplicand / multiplier (sampled with start)
//   busy         high while an operation is running (RUN and DONE states)
//   done         one-cycle pulse: multi holds a new product
//   multi        registered 2*WIDTH-bit product, held until the next product
//
// Optional feature: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero (product values are unchanged).
//
// Timing: start sampled at edge k -> RUN at edges k+1..k+WIDTH, multi loaded
// on the last RUN edge, done visible after edge k+WIDTH+1.
module seq_mult_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     cand,
  input  logic [WIDTH-1:0]     er,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   multi
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic                 sign_q,   sign_d;
  logic [2*WIDTH-1:0]   multi_q,  multi_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  logic [WIDTH-1:0]     cand_mag, er_mag;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_run;

  // Absolute values; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    cand_mag = (signed_mode && cand[WIDTH-1]) ? (~cand + WIDTH'(1)) : cand;
    er_mag   = (signed_mode && er[WIDTH-1])   ? (~er + WIDTH'(1))   : er;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    multi_d  = multi_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_run = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, cand_mag};
          mplier_d = er_mag;
          sign_d   = signed_mode & (cand[WIDTH-1] ^ er[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_run = (mplier_d == '0);
`else
        last_run = (cnt_q == CW'(WIDTH - 1));
`endif
        if (last_run) begin
          multi_d = sign_q ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state, so busy tracks RUN/DONE
    // and done pulses in the cycle after DONE, when multi is already valid.
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      multi_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      multi_q  <= multi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=32 instance (directed cases)
  logic        rst32, start32, sm32;
  logic [31:0] cand32, er32;
  logic        busy32, done32;
  logic [63:0] multi32;

  // WIDTH=8 instance (random regression)
  logic        rst8, start8, sm8;
  logic [7:0]  cand8, er8;
  logic        busy8, done8;
  logic [15:0] multi8;

  seq_mult_param #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst32), .start(start32), .signed_mode(sm32),
    .cand(cand32), .er(er32), .busy(busy32), .done(done32), .multi(multi32)
  );

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8),
    .cand(cand8), .er(er8), .busy(busy8), .done(done8), .multi(multi8)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: plain integer multiply, reduced modulo 2^(2w).
  function automatic logic [127:0] ref_prod(input int w, input bit sm,
                                            input logic [63:0] a, input logic [63:0] b);
    longint sa, sb, p;
    logic [127:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    mask = (128'd1 << (2*w)) - 128'd1;
    return {{64{p[63]}}, p} & mask;
  endfunction

  // Expected number of RUN cycles.
  function automatic int exp_runs(input int w, input bit sm, input logic [63:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [63:0] m;
    int hl;
    m = b;
    if (sm && b[w-1]) m = (64'd1 << w) - b;
    hl = 0;
    for (int i = 0; i < w; i++) if (m[i]) hl = i + 1;
    return (hl < 1) ? 1 : hl;
`else
    return w;
`endif
  endfunction

  // One operation on the 32-bit instance; lat = edges after the start edge
  // until done is seen. Operands are scrambled while busy.
  task automatic op32(input bit sm, input logic [31:0] a, input logic [31:0] b,
                      output logic [63:0] p, output int lat);
    @(negedge clk);
    sm32 = sm; cand32 = a; er32 = b; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; cand32 = $urandom; er32 = $urandom; sm32 = ~sm;
    lat = 0;
    while (!done32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    p = multi32;
    @(negedge clk);
    check("done32_single_pulse", {127'b0, done32}, 128'd0);
  endtask

  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    sm8 = sm; cand8 = a; er8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; cand8 = 8'($urandom); er8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    p = multi8;
    @(negedge clk);
    check("done8_single_pulse", {127'b0, done8}, 128'd0);
  endtask

  task automatic dir32(input string tag, input bit sm, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int lat;
    op32(sm, a, b, p, lat);
    check(tag, {64'b0, p}, ref_prod(32, sm, {32'b0, a}, {32'b0, b}));
    check({tag, "_latency"}, 128'(lat), 128'(exp_runs(32, sm, {32'b0, b}) + 1));
  endtask

  initial begin
    logic [63:0] p32;
    logic [15:0] p8;
    int lat, pulses;
    logic [63:0] first_p;
    bit sm;
    logic [7:0] a8, b8;

    rst32 = 1'b1; start32 = 1'b0; sm32 = 1'b0; cand32 = '0; er32 = '0;
    rst8  = 1'b1; start8  = 1'b0; sm8  = 1'b0; cand8  = '0; er8  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  {127'b0, busy32}, 128'd0);
    check("reset_done",  {127'b0, done32}, 128'd0);
    check("reset_multi", {64'b0, multi32}, 128'd0);

    // Reset wins over a simultaneous start.
    start32 = 1'b1; cand32 = 32'd3; er32 = 32'd4;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    check("rst_over_start_busy", {127'b0, busy32}, 128'd0);
    rst32 = 1'b0; rst8 = 1'b0;

    // Directed products.
    op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p32, lat);
    check("umax_sq", {64'b0, p32}, 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
    check("umax_sq_latency", 128'(lat), 128'(exp_runs(32, 1'b0, 64'hFFFF_FFFF) + 1));
    op32(1'b1, 32'hFFFF_FFFD, 32'd7, p32, lat);
    check("neg3_x_7", {64'b0, p32}, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFEB);
    op32(1'b1, 32'h8000_0000, 32'h8000_0000, p32, lat);
    check("minint_sq", {64'b0, p32}, 128'h0000_0000_0000_0000_4000_0000_0000_0000);
    dir32("s_mixed", 1'b1, 32'h0001_2345, 32'hFFFF_0000);
    dir32("u_zero_er", 1'b0, 32'hDEAD_BEEF, 32'd0);
    dir32("s_minint_x1", 1'b1, 32'h8000_0000, 32'd1);
`ifdef SEQ_MULT_EARLY_TERM_EN
    op32(1'b0, 32'd9, 32'd5, p32, lat);
    check("et_9x5", {64'b0, p32}, 128'd45);
    check("et_9x5_latency", 128'(lat), 128'd4);
    op32(1'b0, 32'd9, 32'd0, p32, lat);
    check("et_er0", {64'b0, p32}, 128'd0);
    check("et_er0_latency", 128'(lat), 128'd2);
`endif

    // Restart attempt 5 cycles into a run is ignored.
    @(negedge clk);
    sm32 = 1'b0; cand32 = 32'd1234; er32 = 32'd5678; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    cand32 = 32'd11; er32 = 32'd13; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    pulses = 0; first_p = '0;
    for (int i = 0; i < 60; i++) begin
      if (done32) begin
        if (pulses == 0) first_p = multi32;
        pulses++;
      end
      @(negedge clk);
    end
    check("restart_pulses", 128'(pulses), 128'd1);
    check("restart_product", {64'b0, first_p}, 128'd7006652);

    // Reset 10 cycles into a run aborts without a done pulse.
    @(negedge clk);
    sm32 = 1'b0; cand32 = 32'd100; er32 = 32'hFFFF_FFFF; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", {127'b0, busy32}, 128'd1);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    check("abort_busy",  {127'b0, busy32}, 128'd0);
    check("abort_done",  {127'b0, done32}, 128'd0);
    check("abort_multi", {64'b0, multi32}, 128'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(pulses), 128'd0);
    dir32("after_abort_6x7", 1'b0, 32'd6, 32'd7);
    check("multi_held", {64'b0, multi32}, 128'd42);

    // WIDTH=8 boundaries and random regression in both modes.
    op8(1'b1, 8'h80, 8'h80, p8, lat);
    check("w8_minint_sq", {112'b0, p8}, 128'h4000);
    op8(1'b0, 8'hFF, 8'hFF, p8, lat);
    check("w8_umax_sq", {112'b0, p8}, 128'hFE01);
    for (int n = 0; n < 1500; n++) begin
      sm = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      op8(sm, a8, b8, p8, lat);
      check("w8_rand_product", {112'b0, p8}, ref_prod(8, sm, {56'b0, a8}, {56'b0, b8}));
      check("w8_rand_latency", 128'(lat), 128'(exp_runs(8, sm, {56'b0, b8}) + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
